// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, word-addressed instruction memory,
// stall/redirect handling and HALT detection for the 5-stage MIPS pipeline.
module if_stage #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  input  logic        imem_we,
  input  logic [31:0] imem_waddr,
  input  logic [31:0] imem_wdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus_4,
  output logic [31:0] if_instruction,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam int unsigned ADDR_W = $clog2(IMEM_DEPTH);

  typedef enum logic {RUN, HALTED} state_t;

  state_t            state;
  logic [31:0]       pc;
  logic [31:0]       count;
  logic [31:0]       mem [IMEM_DEPTH];
  logic [ADDR_W-1:0] rd_idx;
  logic [ADDR_W-1:0] wr_idx;
  logic [31:0]       cur_word;
  logic              unused_bits;

  assign rd_idx      = pc[ADDR_W+1:2];
  assign wr_idx      = imem_waddr[ADDR_W+1:2];
  assign cur_word    = mem[rd_idx];
  assign unused_bits = ^{imem_waddr[31:ADDR_W+2], imem_waddr[1:0], redirect_addr[1:0]};

  // Memory has no reset so a program loaded by the debug unit survives reset.
  always_ff @(posedge clk) begin
    if (imem_we) begin
      mem[wr_idx] <= imem_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      pc    <= '0;
      count <= '0;
    end else if (clk_en && state == RUN && !stall) begin
      if (redirect) begin
        pc    <= {redirect_addr[31:2], 2'b00};
        count <= count + 32'd1;
      end else if (cur_word == HALT_WORD) begin
        state <= HALTED;
      end else begin
        pc    <= pc + 32'd4;
        count <= count + 32'd1;
      end
    end
  end

  assign if_pc          = pc;
  assign if_pc_plus_4   = pc + 32'd4;
  assign if_instruction = (state == HALTED) ? '0 : cur_word;
  assign halted         = (state == HALTED);
  assign fetch_count    = count;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a driver applies stimulus and pushes the
// expected post-edge outputs from a reference model; a monitor pops and compares.
module tb_if_stage;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_en = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        imem_we = 1'b0;
  logic [31:0] imem_waddr = '0;
  logic [31:0] imem_wdata = '0;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus_4;
  logic [31:0] if_instruction;
  logic        halted;
  logic [31:0] fetch_count;

  if_stage #(.IMEM_DEPTH(256), .HALT_WORD(HALT)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .stall(stall),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .if_pc(if_pc), .if_pc_plus_4(if_pc_plus_4), .if_instruction(if_instruction),
    .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        hlt;
    logic [31:0] cnt;
  } exp_t;

  exp_t queue_exp[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: architectural state described by the fetch rules.
  logic [31:0] m_mem [256];
  logic [31:0] m_pc;
  logic        m_halt;
  logic [31:0] m_cnt;

  function automatic int unsigned widx(input logic [31:0] a);
    return (a / 4) % 256;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.pc    = m_pc;
    e.pc4   = m_pc + 32'd4;
    e.instr = m_halt ? 32'd0 : m_mem[widx(m_pc)];
    e.hlt   = m_halt;
    e.cnt   = m_cnt;
    return e;
  endfunction

  // Drive one cycle's inputs at the falling edge and predict the next edge.
  task automatic cyc(input logic rst, input logic ce, input logic st, input logic rd,
                     input logic [31:0] ra, input logic we, input logic [31:0] wa,
                     input logic [31:0] wd);
    @(negedge clk);
    reset = rst; clk_en = ce; stall = st; redirect = rd; redirect_addr = ra;
    imem_we = we; imem_waddr = wa; imem_wdata = wd;
    if (rst) begin
      m_pc = 0; m_halt = 0; m_cnt = 0;
    end else if (ce && !m_halt && !st) begin
      if (rd) begin
        m_pc = ra & ~32'd3;
        m_cnt++;
      end else if (m_mem[widx(m_pc)] == HALT) begin
        m_halt = 1;
      end else begin
        m_pc = m_pc + 4;
        m_cnt++;
      end
    end
    if (we) m_mem[widx(wa)] = wd;
    queue_exp.push_back(snapshot());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic async_reset_check(input string name);
    @(negedge clk);
    #2;
    reset = 1'b1;
    m_pc = 0; m_halt = 0; m_cnt = 0;
    #1;
    chk({name, "_pc"}, if_pc, 32'd0);
    chk({name, "_halted"}, {31'd0, halted}, 32'd0);
    chk({name, "_count"}, fetch_count, 32'd0);
    chk({name, "_instr"}, if_instruction, m_mem[0]);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (queue_exp.size() > 0) begin
        e = queue_exp.pop_front();
        chk("pc", if_pc, e.pc);
        chk("pc_plus_4", if_pc_plus_4, e.pc4);
        chk("instruction", if_instruction, e.instr);
        chk("halted", {31'd0, halted}, {31'd0, e.hlt});
        chk("fetch_count", fetch_count, e.cnt);
      end
    end
  end

  initial begin : driver
    logic [31:0] wd;
    m_pc = 0; m_halt = 0; m_cnt = 0;
    #1;
    chk("reset_pc", if_pc, 32'd0);
    chk("reset_pc_plus_4", if_pc_plus_4, 32'd4);
    chk("reset_halted", {31'd0, halted}, 32'd0);
    chk("reset_count", fetch_count, 32'd0);

    // Program load under reset: random fill, then the sequential-fetch words.
    for (int i = 0; i < 256; i++) begin
      wd = $urandom();
      if (wd == HALT) wd = 32'h1;
      cyc(1, 0, 0, 0, 0, 1, i * 4, wd);
    end
    cyc(1, 0, 0, 0, 0, 1, 32'h0, 32'h11);
    cyc(1, 0, 0, 0, 0, 1, 32'h4, 32'h22);
    cyc(1, 0, 0, 0, 0, 1, 32'h8, 32'h33);

    // Sequential fetch, then stall and clk_en freeze at PC 8.
    run(2);
    cyc(0, 1, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    run(1);

    // Redirect, redirect dropped under stall.
    cyc(0, 1, 0, 1, 32'h4, 0, 0, 0);
    cyc(0, 1, 1, 1, 32'h43, 0, 0, 0);
    cyc(0, 1, 0, 1, 32'h43, 0, 0, 0);

    // Memory wrap, write to the current word while stalled, 32-bit PC wrap.
    cyc(0, 1, 0, 1, 32'h3FC, 0, 0, 0);
    run(1);
    cyc(0, 1, 1, 0, 0, 1, 32'h400, 32'hABCD);
    cyc(0, 1, 0, 1, 32'hFFFF_FFFE, 0, 0, 0);
    run(2);

    // HALT after three NOPs; redirect while halted is ignored.
    cyc(0, 0, 0, 0, 0, 1, 32'h0, 32'h0);
    cyc(0, 0, 0, 0, 0, 1, 32'h4, 32'h0);
    cyc(0, 0, 0, 0, 0, 1, 32'h8, 32'h0);
    cyc(0, 0, 0, 0, 0, 1, 32'hC, HALT);
    cyc(0, 1, 0, 1, 32'h0, 0, 0, 0);
    run(5);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 1, 32'h80, 0, 0, 0);
    run(6);

    async_reset_check("async_reset_halted");
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    run(2);

    // Randomized traffic including HALT writes and occasional resets.
    for (int i = 0; i < 400; i++) begin
      logic        rs, ce, st, rd, we;
      logic [31:0] ra, wa;
      rs = ($urandom_range(99) < 2);
      ce = ($urandom_range(99) < 85);
      st = ($urandom_range(99) < 20);
      rd = ($urandom_range(99) < 15);
      we = ($urandom_range(99) < 12);
      ra = $urandom_range(1023);
      if ($urandom_range(9) == 0) ra = $urandom();
      wa = ($urandom_range(1) == 1) ? m_pc : $urandom();
      wd = ($urandom_range(3) == 0) ? HALT : $urandom();
      cyc(rs, ce, st, rd, ra, we, wa, wd);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    repeat (4) @(posedge clk);
    #3;
    chk("scoreboard_drained", queue_exp.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
